// File: rtl/led_pkg.sv
// Shared types, constants and the saturating ramp helper for the LED fade driver.
package led_pkg;

  localparam int unsigned BRIGHT_W     = 8;
  localparam logic [7:0]  BRIGHT_MAX   = 8'd255;
  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned LED_N        = 3;

  localparam int unsigned PWM_DIV_DEF  = 8;
  localparam int unsigned RAMP_DIV_DEF = 49_020;
  localparam int unsigned STEP_DEF     = 1;

  typedef logic [BRIGHT_W-1:0] bright_t;

  // One ramp step toward full-on (up=1) or full-off (up=0), saturating at both ends.
  function automatic bright_t ramp_step(input bright_t cur, input logic up, input bright_t step);
    logic [BRIGHT_W:0] sum;
    bright_t           res;
    sum = {1'b0, cur} + {1'b0, step};
    if (up) begin
      if (sum > {1'b0, BRIGHT_MAX}) begin
        res = BRIGHT_MAX;
      end else begin
        res = sum[BRIGHT_W-1:0];
      end
    end else begin
      if (cur < step) begin
        res = '0;
      end else begin
        res = cur - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Sequencer-to-pin bundle: requested LED levels in, PWM pin drive out.
interface led_fade_driver_if;
  import led_pkg::*;

  logic [LED_N-1:0] led_req;
  logic [LED_N-1:0] led_out;

  modport master (output led_req, input  led_out);
  modport slave  (input  led_req, output led_out);

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness ramp, period-aligned shadow duty, PWM compare and output flop.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned STEP           = STEP_DEF,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req,
  input  logic    ramp_tick,
  input  logic    pwm_tick,
  input  bright_t pwm_cnt,
  output logic    led_out
);

  localparam bright_t STEP_B   = bright_t'(STEP);
  localparam logic    IDLE_LVL = LED_ACTIVE_LOW;

  bright_t r_bright;
  bright_t r_shadow;
  logic    r_led;
  bright_t w_bright_nxt;
  logic    w_on;
  logic    w_period_end;

  // Next brightness: one saturating step toward the requested end, only on a ramp tick.
  always_comb begin
    w_bright_nxt = r_bright;
    if (ramp_tick) begin
      w_bright_nxt = ramp_step(r_bright, req, STEP_B);
    end else begin
      w_bright_nxt = r_bright;
    end
  end

  // Full scale is forced on so that 255 means solid, not 255/256.
  always_comb begin
    w_period_end = pwm_tick && (pwm_cnt == BRIGHT_MAX);
    w_on         = (r_shadow == BRIGHT_MAX) || (pwm_cnt < r_shadow);
  end

  // Brightness, shadow duty and pin flop; the shadow takes the pre-update brightness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bright <= '0;
      r_shadow <= '0;
      r_led    <= IDLE_LVL;
    end else begin
      r_bright <= w_bright_nxt;
      if (w_period_end) begin
        r_shadow <= r_bright;
      end else begin
        r_shadow <= r_shadow;
      end
      r_led <= w_on ^ IDLE_LVL;
    end
  end

  assign led_out = r_led;

endmodule

// File: rtl/led_fade_driver.sv
// Three-channel LED cross-fade driver: shared prescalers and PWM counter feeding three channels.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int unsigned PWM_DIV        = PWM_DIV_DEF,
  parameter int unsigned RAMP_DIV       = RAMP_DIV_DEF,
  parameter int unsigned STEP           = STEP_DEF,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  led_fade_driver_if.slave bus
);

  localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);

  logic [LED_N-1:0]  r_req_q;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic [PRE_W-1:0]  r_pwm_pre;
  bright_t           r_pwm_cnt;
  logic              w_ramp_tick;
  logic              w_pwm_tick;
  logic [LED_N-1:0]  w_led;

  // Tick decode from the current prescaler values.
  always_comb begin
    w_ramp_tick = (r_ramp_cnt == RAMP_LAST);
    w_pwm_tick  = (r_pwm_pre == PRE_LAST);
  end

  // Input register and the shared ramp / PWM timebase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_q    <= '0;
      r_ramp_cnt <= '0;
      r_pwm_pre  <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_req_q <= bus.led_req;
      if (w_ramp_tick) begin
        r_ramp_cnt <= '0;
      end else begin
        r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
      end
      if (w_pwm_tick) begin
        r_pwm_pre <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pwm_pre <= r_pwm_pre + PRE_W'(1);
        r_pwm_cnt <= r_pwm_cnt;
      end
    end
  end

  led_pwm_channel #(.STEP(STEP), .LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (r_req_q[0]),
    .ramp_tick (w_ramp_tick),
    .pwm_tick  (w_pwm_tick),
    .pwm_cnt   (r_pwm_cnt),
    .led_out   (w_led[0])
  );

  led_pwm_channel #(.STEP(STEP), .LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (r_req_q[1]),
    .ramp_tick (w_ramp_tick),
    .pwm_tick  (w_pwm_tick),
    .pwm_cnt   (r_pwm_cnt),
    .led_out   (w_led[1])
  );

  led_pwm_channel #(.STEP(STEP), .LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (r_req_q[2]),
    .ramp_tick (w_ramp_tick),
    .pwm_tick  (w_pwm_tick),
    .pwm_cnt   (r_pwm_cnt),
    .led_out   (w_led[2])
  );

  assign bus.led_out = w_led;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: ramp table, saturation, duty, cross-fade, reversal, reset.
module tb_led_fade_driver;
  import led_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  led_fade_driver_if if_main ();
  led_fade_driver_if if_al ();
  led_fade_driver_if if_duty ();

  led_fade_driver #(.PWM_DIV(1), .RAMP_DIV(4), .STEP(64), .LED_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_main)
  );
  led_fade_driver #(.PWM_DIV(1), .RAMP_DIV(4), .STEP(64), .LED_ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .bus(if_al)
  );
  // Ramp ticks land exactly on PWM period ends, exercising the coincident-tick rule.
  led_fade_driver #(.PWM_DIV(1), .RAMP_DIV(256), .STEP(128), .LED_ACTIVE_LOW(1'b0)) u_duty (
    .clk(clk), .rst_n(rst_n), .bus(if_duty)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [2:0] req;
    int         b0;
    int         b1;
    int         b2;
  } vec_t;
  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bright(input string name, input int e0, input int e1, input int e2);
    check({name, "_b0"}, int'(u_dut.u_ch0.r_bright), e0);
    check({name, "_b1"}, int'(u_dut.u_ch1.r_bright), e1);
    check({name, "_b2"}, int'(u_dut.u_ch2.r_bright), e2);
  endtask

  initial begin
    int err_lo;
    int highs;
    int win_err;
    int sat_err;
    int exp_on;

    vecs[0]  = '{3'b100,   0,   0,  64};
    vecs[1]  = '{3'b100,   0,   0, 128};
    vecs[2]  = '{3'b100,   0,   0, 192};
    vecs[3]  = '{3'b100,   0,   0, 255};
    vecs[4]  = '{3'b100,   0,   0, 255};
    vecs[5]  = '{3'b010,   0,  64, 191};
    vecs[6]  = '{3'b010,   0, 128, 127};
    vecs[7]  = '{3'b010,   0, 192,  63};
    vecs[8]  = '{3'b010,   0, 255,   0};
    vecs[9]  = '{3'b011,  64, 255,   0};
    vecs[10] = '{3'b011, 128, 255,   0};
    vecs[11] = '{3'b010,  64, 255,   0};
    vecs[12] = '{3'b010,   0, 255,   0};
    vecs[13] = '{3'b010,   0, 255,   0};

    // Reset with every request high.
    if_main.led_req = 3'b111;
    if_al.led_req   = 3'b111;
    if_duty.led_req = 3'b010;
    rst_n = 1'b0;
    @(negedge clk);
    repeat (3) step();
    check("rst_led_out", int'(if_main.led_out), 0);
    check("rst_led_out_al", int'(if_al.led_out), 7);
    check_bright("rst", 0, 0, 0);
    check("rst_req_q", int'(u_dut.r_req_q), 0);

    // Duty accuracy on the aligned-tick instance.
    rst_n = 1'b1;
    cyc = 0;
    err_lo = 0;
    highs = 0;
    win_err = 0;
    for (int k = 1; k <= 768; k++) begin
      step();
      if (cyc == 256) check("duty_bright_t1", int'(u_duty.u_ch1.r_bright), 128);
      if (cyc == 512) check("duty_bright_t2", int'(u_duty.u_ch1.r_bright), 255);
      if (cyc <= 512 && if_duty.led_out[1]) err_lo = err_lo + 1;
      if (cyc >= 513) begin
        exp_on = ((cyc - 513) < 128) ? 1 : 0;
        highs = highs + int'(if_duty.led_out[1]);
        if (int'(if_duty.led_out[1]) != exp_on) win_err = win_err + 1;
      end
    end
    check("duty_dark_before_load", err_lo, 0);
    check("duty_high_count", highs, 128);
    check("duty_window_errs", win_err, 0);

    // Main table: each row changes the request right after a ramp tick, then waits one tick.
    rst_n = 1'b0;
    if_main.led_req = 3'b100;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      if_main.led_req = vecs[i].req;
      repeat (4) step();
      check_bright($sformatf("row%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2);
      if (i == 4) begin
        // Full brightness reaches the pin only after the first period boundary at clk 256.
        sat_err = 0;
        while (cyc < 512) begin
          step();
          if (cyc == 256) check("sat_before_boundary", int'(if_main.led_out[2]), 0);
          if (cyc >= 257 && !if_main.led_out[2]) sat_err = sat_err + 1;
        end
        check("sat_solid_on_errs", sat_err, 0);
      end
    end

    // Reset pulse mid-fade.
    if_main.led_req = 3'b100;
    repeat (12) step();
    check("midfade_b2_before", int'(u_dut.u_ch2.r_bright), 192);
    rst_n = 1'b0;
    step();
    check_bright("midfade_rst", 0, 0, 0);
    check("midfade_led_out", int'(if_main.led_out), 0);
    check("midfade_req_q", int'(u_dut.r_req_q), 0);
    check("midfade_pwm_cnt", int'(u_dut.r_pwm_cnt), 0);
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) step();
    check("restart_b2_clk3", int'(u_dut.u_ch2.r_bright), 0);
    step();
    check("restart_b2_clk4", int'(u_dut.u_ch2.r_bright), 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
